// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the Ethernet TX frame arbiter and its RX-side sibling.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PASS = 2'd1,
        ARB_DROP = 2'd2
    } arb_state_e;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// Byte-wide multi-source AXI-Stream bundle in front of the single MAC TX port.
interface eth_tx_frame_arbiter_if #(
    parameter int C_NUM_SOURCES = 2
);
    logic [8*C_NUM_SOURCES-1:0] s_axis_tdata;
    logic [C_NUM_SOURCES-1:0]   s_axis_tvalid;
    logic [C_NUM_SOURCES-1:0]   s_axis_tlast;
    logic [C_NUM_SOURCES-1:0]   s_axis_tuser;
    logic [C_NUM_SOURCES-1:0]   s_axis_tready;
    logic [7:0]                 m_axis_tdata;
    logic                       m_axis_tvalid;
    logic                       m_axis_tlast;
    logic                       m_axis_tuser;
    logic                       m_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request after `last`, wrapping.
module rr_pick
    import eth_tx_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    int cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        // k = N revisits `last` itself, so a lone requester can win back to back.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing the MAC TX AXI-Stream port between byte sources.
// state | meaning
// IDLE  | no owner; pick next requester after `last`
// PASS  | owner's stream passed straight through to the MAC
// DROP  | frame hit C_MAX_LEN; swallow owner's bytes up to its tlast
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int C_NUM_SOURCES = 2,
    parameter int C_MAX_LEN     = 1522
) (
    input  logic                     gtx_clk,
    input  logic                     gtx_rst_n,
    eth_tx_frame_arbiter_if.slave    bus,
    output logic [C_NUM_SOURCES-1:0] grant,
    output logic                     trunc_pulse
);
    localparam int IDX_W = clog2(C_NUM_SOURCES);
    localparam int LEN_W = clog2(C_MAX_LEN + 1);

    localparam logic [1:0] ST_IDLE = 2'(ARB_IDLE);
    localparam logic [1:0] ST_PASS = 2'(ARB_PASS);
    localparam logic [1:0] ST_DROP = 2'(ARB_DROP);

    localparam logic [IDX_W-1:0]         LAST_RST  = IDX_W'(C_NUM_SOURCES - 1);
    localparam logic [LEN_W-1:0]         LEN_TRUNC = LEN_W'(C_MAX_LEN - 1);
    localparam logic [LEN_W-1:0]         LEN_SAT   = LEN_W'(C_MAX_LEN);
    localparam logic [C_NUM_SOURCES-1:0] GRANT_ONE = C_NUM_SOURCES'(1);

    logic [1:0]       state;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [LEN_W-1:0] len;
    logic [7:0]       src_data [C_NUM_SOURCES];
    logic             src_valid;
    logic             src_last;
    logic             src_user;
    logic             at_max;
    logic             mac_beat;

    rr_pick #(
        .N     (C_NUM_SOURCES),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.s_axis_tvalid),
        .last  (last),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        for (int i = 0; i < C_NUM_SOURCES; i++) begin
            src_data[i] = bus.s_axis_tdata[8*i +: 8];
        end
    end

    assign src_valid = bus.s_axis_tvalid[sel];
    assign src_last  = bus.s_axis_tlast[sel];
    assign src_user  = bus.s_axis_tuser[sel];
    assign at_max    = (len == LEN_TRUNC);
    assign mac_beat  = bus.m_axis_tvalid && bus.m_axis_tready;

    // Zero-latency mux; m_axis_tvalid depends only on state and the source, never on MAC ready.
    always_comb begin
        bus.m_axis_tdata  = 8'h00;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tuser  = 1'b0;
        bus.s_axis_tready = '0;
        if (state == ST_PASS) begin
            bus.m_axis_tdata       = src_data[sel];
            bus.m_axis_tvalid      = src_valid;
            bus.m_axis_tlast       = src_last | at_max;
            bus.m_axis_tuser       = src_user | (at_max & ~src_last);
            bus.s_axis_tready[sel] = bus.m_axis_tready;
        end else if (state == ST_DROP) begin
            bus.s_axis_tready[sel] = 1'b1;
        end
    end

    always_ff @(posedge gtx_clk or negedge gtx_rst_n) begin
        if (!gtx_rst_n) begin
            state       <= ST_IDLE;
            sel         <= '0;
            last        <= LAST_RST;
            len         <= '0;
            grant       <= '0;
            trunc_pulse <= 1'b0;
        end else begin
            trunc_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        sel   <= pick_idx;
                        last  <= pick_idx;
                        grant <= GRANT_ONE << pick_idx;
                        len   <= '0;
                        state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (mac_beat) begin
                        if (len != LEN_SAT) begin
                            len <= len + 1'b1;
                        end
                        if (src_last) begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end else if (at_max) begin
                            state       <= ST_DROP;
                            trunc_pulse <= 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (src_valid && src_last) begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Randomized bench for eth_tx_frame_arbiter against a queue-level round-robin frame model.
module tb_eth_tx_frame_arbiter;
    localparam int N       = 3;
    localparam int MAX_LEN = 128;

    logic         gtx_clk = 1'b0;
    logic         gtx_rst_n;
    logic [N-1:0] grant;
    logic         trunc_pulse;

    eth_tx_frame_arbiter_if #(.C_NUM_SOURCES(N)) bus_if ();

    eth_tx_frame_arbiter #(
        .C_NUM_SOURCES (N),
        .C_MAX_LEN     (MAX_LEN)
    ) dut (
        .gtx_clk     (gtx_clk),
        .gtx_rst_n   (gtx_rst_n),
        .bus         (bus_if),
        .grant       (grant),
        .trunc_pulse (trunc_pulse)
    );

    always #5 gtx_clk = ~gtx_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Source bytes as {data, last, user}; src_q feeds the drivers, mdl_q feeds the model.
    logic [9:0]  src_q  [N][$];
    logic [9:0]  mdl_q  [N][$];
    int          flen_q [N][$];
    logic [10:0] exp_q  [$];
    int          own_q  [$];
    int          mdl_last = N - 1;
    bit          mid [N];
    bit          dropping;
    bit          trunc_exp;
    logic [N-1:0] prev_grant;
    int          idle_cnt;
    int          frames_seen;
    int          mac_beats;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus_if.s_axis_tdata  = '0;
        bus_if.s_axis_tvalid = '0;
        bus_if.s_axis_tlast  = '0;
        bus_if.s_axis_tuser  = '0;
        bus_if.m_axis_tready = 1'b1;
    endtask

    task automatic add_frame(input int src, input int len, input bit last_user);
        logic [7:0] d;
        logic       u;
        for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            u = (b == len - 1) ? last_user : ($urandom_range(0, 7) == 0);
            src_q[src].push_back({d, (b == len - 1), u});
            mdl_q[src].push_back({d, (b == len - 1), u});
        end
        flen_q[src].push_back(len);
    endtask

    // Sources always present a frame's first byte, so the owner order is pure round robin
    // over non-empty queues; over-long frames are cut to MAX_LEN with tlast/tuser forced.
    task automatic plan_frames();
        int         pick;
        int         len;
        bit         cut;
        logic [9:0] ent;
        while (1) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && flen_q[(mdl_last + k) % N].size() > 0) pick = (mdl_last + k) % N;
            end
            if (pick < 0) break;
            len = flen_q[pick].pop_front();
            for (int b = 0; b < len; b++) begin
                ent = mdl_q[pick].pop_front();
                if (b < MAX_LEN) begin
                    cut = (b == MAX_LEN - 1) && (len > MAX_LEN);
                    exp_q.push_back({cut, ent[9:2], ent[1] | cut, ent[0] | cut});
                end
            end
            own_q.push_back(pick);
            mdl_last = pick;
        end
    endtask

    task automatic cycle_step(input bit gaps, input int bp_pct);
        logic [9:0]  cur;
        logic [10:0] e;
        int          owner;
        @(negedge gtx_clk);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                cur = src_q[i][0];
                bus_if.s_axis_tdata[8*i +: 8] = cur[9:2];
                bus_if.s_axis_tlast[i]        = cur[1];
                bus_if.s_axis_tuser[i]        = cur[0];
                bus_if.s_axis_tvalid[i]       = !(gaps && mid[i] && ($urandom_range(0, 3) == 0));
            end else begin
                bus_if.s_axis_tdata[8*i +: 8] = 8'h00;
                bus_if.s_axis_tlast[i]        = 1'b0;
                bus_if.s_axis_tuser[i]        = 1'b0;
                bus_if.s_axis_tvalid[i]       = 1'b0;
            end
        end
        bus_if.m_axis_tready = ($urandom_range(0, 99) >= bp_pct);
        #1;
        check_val("rdy_nongrant", 32'(bus_if.s_axis_tready & ~grant), 32'(0));
        check_val("trunc_pulse", 32'(trunc_pulse), 32'(trunc_exp));
        trunc_exp = 1'b0;
        if (grant != '0 && prev_grant == '0) begin
            check_val("grant_pending", 32'(own_q.size() != 0), 32'(1));
            if (own_q.size() != 0) begin
                owner = own_q.pop_front();
                check_val("grant", 32'(grant), 32'(1) << owner);
            end
            if (frames_seen > 0) check_val("frame_gap", 32'(idle_cnt), 32'(1));
            frames_seen++;
            idle_cnt = 0;
        end
        if (grant == '0) begin
            idle_cnt++;
            check_val("idle_valid", 32'(bus_if.m_axis_tvalid), 32'(0));
            check_val("idle_rdy", 32'(bus_if.s_axis_tready), 32'(0));
        end else if (dropping) begin
            check_val("drop_valid", 32'(bus_if.m_axis_tvalid), 32'(0));
            check_val("drop_rdy", 32'(bus_if.s_axis_tready), 32'(grant));
        end else begin
            check_val("pass_rdy", 32'(bus_if.s_axis_tready), bus_if.m_axis_tready ? 32'(grant) : 32'(0));
            check_val("pass_valid", 32'(bus_if.m_axis_tvalid), 32'(|(bus_if.s_axis_tvalid & grant)));
        end
        if (bus_if.m_axis_tvalid && bus_if.m_axis_tready) begin
            check_val("beat_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("beat", 32'({bus_if.m_axis_tdata, bus_if.m_axis_tlast, bus_if.m_axis_tuser}),
                          32'(e[9:0]));
                if (e[10]) begin
                    dropping  = 1'b1;
                    trunc_exp = 1'b1;
                end
            end
            mac_beats++;
        end
        for (int i = 0; i < N; i++) begin
            if (bus_if.s_axis_tvalid[i] && bus_if.s_axis_tready[i] && src_q[i].size() > 0) begin
                cur = src_q[i].pop_front();
                mid[i] = !cur[1];
                if (dropping && cur[1] && grant[i]) dropping = 1'b0;
            end
        end
        prev_grant = grant;
    endtask

    function automatic bit all_drained();
        bit d;
        d = (exp_q.size() == 0) && (own_q.size() == 0) && (grant == '0);
        for (int i = 0; i < N; i++) d = d && (src_q[i].size() == 0);
        return d;
    endfunction

    task automatic run_phase(input string name, input bit gaps, input int bp_pct, input int budget);
        bit done;
        plan_frames();
        frames_seen = 0;
        idle_cnt    = 0;
        done        = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            cycle_step(gaps, bp_pct);
            done = all_drained();
        end
        check_val($sformatf("%s_done", name), 32'(done), 32'(1));
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_grant"}, 32'(grant), 32'(0));
        check_val({tag, "_rdy"}, 32'(bus_if.s_axis_tready), 32'(0));
        check_val({tag, "_mac"}, 32'({bus_if.m_axis_tvalid, bus_if.m_axis_tdata, bus_if.m_axis_tlast,
                                      bus_if.m_axis_tuser, trunc_pulse}), 32'(0));
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
            flen_q[i].delete();
            mid[i] = 1'b0;
        end
        exp_q.delete();
        own_q.delete();
        dropping   = 1'b0;
        trunc_exp  = 1'b0;
        prev_grant = '0;
        mdl_last   = N - 1;
    endtask

    initial begin
        gtx_rst_n = 1'b0;
        drive_idle();
        clear_model();
        mac_beats = 0;
        repeat (3) @(negedge gtx_clk);
        #1 check_zero_outputs("in_reset");
        gtx_rst_n = 1'b1;
        repeat (2) begin
            @(negedge gtx_clk);
            #1 check_zero_outputs("post_reset");
        end

        add_frame(0, 10, 1'b0);
        add_frame(1, 10, 1'b1);
        run_phase("first_pick", 1'b0, 0, 200);

        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < N; s++) add_frame(s, 64, f[0]);
        end
        run_phase("fairness", 1'b0, 0, 1000);

        add_frame(1, 100, 1'b0);
        run_phase("backpressure", 1'b0, 50, 1000);

        add_frame(0, 200, 1'b0);
        add_frame(2, 20, 1'b1);
        run_phase("truncation", 1'b0, 25, 2000);

        add_frame(1, MAX_LEN, 1'b1);
        add_frame(2, MAX_LEN + 1, 1'b0);
        add_frame(0, MAX_LEN - 1, 1'b1);
        run_phase("boundary", 1'b0, 0, 2000);

        for (int f = 0; f < 12; f++) begin
            add_frame($urandom_range(0, N - 1), $urandom_range(1, 150), 1'($urandom_range(0, 1)));
        end
        run_phase("random", 1'b1, 30, 20000);

        add_frame(1, 30, 1'b0);
        add_frame(2, 30, 1'b0);
        plan_frames();
        frames_seen = 0;
        mac_beats   = 0;
        for (int c = 0; c < 300 && mac_beats < 10; c++) cycle_step(1'b0, 0);
        check_val("mid_frame_reached", 32'(mac_beats >= 10), 32'(1));
        #3 gtx_rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        clear_model();
        drive_idle();
        repeat (2) @(negedge gtx_clk);
        gtx_rst_n = 1'b1;
        for (int s = N - 1; s >= 0; s--) add_frame(s, 8, 1'b0);
        run_phase("after_reset", 1'b0, 0, 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
